// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampling UART receiver framing start/data/optional parity/stop.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 mid-bit sampling instead of a single sample.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg, state_next;
  logic [PRESCALE_W-1:0]   edge_cnt_reg, edge_cnt_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
  logic [PRESCALE_W-1:0]   p_reg, p_next;
  logic                    par_en_reg, par_en_next;
  logic                    par_typ_reg, par_typ_next;
  logic                    par_bad_reg, par_bad_next;
  logic [DATA_WIDTH-1:0]   p_data_reg, p_data_next;
  logic                    data_valid_reg, data_valid_next;
  logic                    par_err_reg, par_err_next;
  logic                    stp_err_reg, stp_err_next;
  logic                    s_mid_reg;
  logic                    bit_val;
  logic [PRESCALE_W-1:0]   half, half_p1, last_edge;
  logic                    bit_end, decide;

  assign half      = p_reg >> 1;
  assign half_p1   = half + PRESCALE_W'(1);
  assign last_edge = p_reg - PRESCALE_W'(1);
  assign bit_end   = (edge_cnt_reg == last_edge);
  assign decide    = (edge_cnt_reg == half_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_mid_reg <= 1'b1;
    else if (edge_cnt_reg == half) s_mid_reg <= RX_IN;
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic                  s_early_reg;
  logic [PRESCALE_W-1:0] half_m1;

  assign half_m1 = half - PRESCALE_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_early_reg <= 1'b1;
    else if (edge_cnt_reg == half_m1) s_early_reg <= RX_IN;
  end

  // The third vote is the live line at the decision cycle itself.
  assign bit_val = (s_early_reg & s_mid_reg) | (s_early_reg & RX_IN) | (s_mid_reg & RX_IN);
`else
  assign bit_val = s_mid_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      edge_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      p_reg          <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      par_bad_reg    <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      edge_cnt_reg   <= edge_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      p_reg          <= p_next;
      par_en_reg     <= par_en_next;
      par_typ_reg    <= par_typ_next;
      par_bad_reg    <= par_bad_next;
      p_data_reg     <= p_data_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    edge_cnt_next   = bit_end ? '0 : edge_cnt_reg + PRESCALE_W'(1);
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    p_next          = p_reg;
    par_en_next     = par_en_reg;
    par_typ_next    = par_typ_reg;
    par_bad_next    = par_bad_reg;
    p_data_next     = p_data_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        edge_cnt_next = '0;
        bit_cnt_next  = '0;
        if (!RX_IN) begin
          state_next   = START;
          p_next       = Prescale;
          par_en_next  = PAR_EN;
          par_typ_next = PAR_TYP;
          par_bad_next = 1'b0;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_next    = IDLE;
          edge_cnt_next = '0;
        end else if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (decide) shift_next = {bit_val, shift_reg[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (decide) par_bad_next = (bit_val != ((^shift_reg) ^ par_typ_reg));
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        // Leave mid-stop so a back-to-back start bit is caught on its first low cycle.
        if (decide) begin
          state_next    = IDLE;
          edge_cnt_next = '0;
          stp_err_next  = ~bit_val;
          par_err_next  = par_bad_reg;
          if (bit_val && !par_bad_reg) begin
            data_valid_next = 1'b1;
            p_data_next     = shift_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign P_DATA     = p_data_reg;
  assign Data_Valid = data_valid_reg;
  assign Par_Err    = par_err_reg;
  assign Stp_Err    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed serial frames into uart_rx; expected pulses are queued at
// stimulus time and matched (value and latency) when the receiver reports a frame.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (rx_in),
    .Prescale   (prescale),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .Par_Err    (par_err),
    .Stp_Err    (stp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       dv;
    logic       pe;
    logic       se;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame-level monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (data_valid || par_err || stp_err)) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", 32'({data_valid, par_err, stp_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("data_valid", 32'(data_valid), 32'(e.dv));
        check("par_err", 32'(par_err), 32'(e.pe));
        check("stp_err", 32'(stp_err), 32'(e.se));
        check("p_data", 32'(p_data), 32'(e.data));
        check("latency", 32'(cyc), 32'(e.cyc));
        $display("frame: dv=%0b pe=%0b se=%0b p_data=%02h cycle=%0d", data_valid, par_err,
                 stp_err, p_data, cyc);
      end
    end
  end

  task automatic drive_bit(input logic v, input int p, input bit glitch);
    rx_in = v;
    if (glitch) begin
      repeat (p / 2 + 1) @(negedge clk);
      rx_in = ~v;
      @(negedge clk);
      rx_in = v;
      repeat (p - p / 2 - 2) @(negedge clk);
    end else begin
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                      input bit bad_par, input bit stop, input int glitch_bit,
                      input bit mid_cfg);
    exp_t e;
    logic par;
    par      = (^d) ^ ptyp ^ bad_par;
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    e.pe     = pen & bad_par;
    e.se     = ~stop;
    e.dv     = ~(e.pe | e.se);
    e.data   = e.dv ? d : last_good;
    if (e.dv) last_good = d;
    e.cyc    = cyc + 1 + (1 + 8 + int'(pen)) * p + p / 2 + 2;
    sb.push_back(e);
    drive_bit(1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (mid_cfg && i == 2) begin
        par_en   = ~pen;
        par_typ  = ~ptyp;
        prescale = 6'd8;
      end
      drive_bit(d[i], p, glitch_bit == i);
    end
    if (pen) drive_bit(par, p, 1'b0);
    drive_bit(stop, p, 1'b0);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    rst      = 1'b1;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_p_data", 32'(p_data), 32'd0);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_par_err", 32'(par_err), 32'd0);
    check("reset_stp_err", 32'(stp_err), 32'd0);
    rst = 1'b0;
    idle(4);

    // Good frame, then the same byte with a corrupted parity bit.
    send(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(8);
    wait_empty("drain_basic", 200);
    send(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(8);
    wait_empty("drain_par_err", 200);

    // Stop bit low, then recovery with a clean frame.
    send(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    idle(48);
    wait_empty("drain_stp_err", 200);
    send(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(8);
    wait_empty("drain_recover", 200);

    // Two-cycle low glitch must be rejected silently.
    prescale = 6'd16;
    rx_in    = 1'b0;
    repeat (2) @(negedge clk);
    idle(60);
    check("glitch_queue", 32'(sb.size()), 32'd0);
    check("glitch_p_data", 32'(p_data), 32'h5A);

`ifdef RX_MAJORITY_VOTE_EN
    send(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle(8);
    wait_empty("drain_vote", 200);
`endif

    // Back-to-back frames; config is changed mid-way through the first.
    send(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1);
    send(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(8);
    wait_empty("drain_b2b", 400);

    // Reset in the middle of data bit 4.
    rd       = 8'hC3;
    prescale = 6'd16;
    par_en   = 1'b0;
    drive_bit(1'b0, 16, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i], 16, 1'b0);
    rx_in = rd[4];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_p_data", 32'(p_data), 32'd0);
    check("midrst_data_valid", 32'(data_valid), 32'd0);
    check("midrst_par_err", 32'(par_err), 32'd0);
    check("midrst_stp_err", 32'(stp_err), 32'd0);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    last_good = 8'h00;
    idle(8);
    send(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(8);
    wait_empty("drain_after_rst", 200);
    check("final_p_data", 32'(p_data), 32'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
